// File: rtl/sr_to_t_ff.sv
// sr_to_t_ff: single-bit toggle flip-flop built from an explicit SR core
// driven by T-to-SR excitation logic (S = T & ~Q, R = T & Q).
// Optional debug build: define SR_TO_T_DEBUG_EN to expose the set/reset
// terms (sr_s, sr_r), a sticky registered illegal-combination flag
// (sr_illegal) and a simulation-only check on the S=R=1 combination.
module sr_to_t_ff (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q,
  output logic Q_n
`ifdef SR_TO_T_DEBUG_EN
  ,
  output logic sr_s,
  output logic sr_r,
  output logic sr_illegal
`endif
);

  logic s;
  logic r;

  // Excitation logic: set when toggling from 0, reset when toggling from 1
  always_comb begin
    s = T & ~Q;
    r = T & Q;
  end

  // SR core; S=R=1 cannot come from the excitation logic but is defined as hold
  always_ff @(posedge clk) begin
    if (reset) begin
      Q <= 1'b0;
    end else begin
      unique case ({s, r})
        2'b10:   Q <= 1'b1;
        2'b01:   Q <= 1'b0;
        default: Q <= Q;
      endcase
    end
  end

  // Complement output straight from the register
  always_comb begin
    Q_n = ~Q;
  end

`ifdef SR_TO_T_DEBUG_EN
  // Expose the internal set/reset terms
  always_comb begin
    sr_s = s;
    sr_r = r;
  end

  // Sticky flag recording any edge that saw S=R=1 outside reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_illegal <= 1'b0;
    end else if (s && r) begin
      sr_illegal <= 1'b1;
    end
  end

  // Simulation-only check on the illegal SR combination
  a_no_illegal_sr : assert property (@(posedge clk) disable iff (reset) !(s && r))
    else $error("sr_to_t_ff: illegal S=1 R=1 combination at clock edge");
`endif

endmodule

// File: tb/tb_sr_to_t_ff.sv
// tb_sr_to_t_ff: directed-vector bench for sr_to_t_ff. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// Debug-port checks are compiled in when SR_TO_T_DEBUG_EN is defined.
module tb_sr_to_t_ff;

  logic clk;
  logic reset;
  logic T;
  logic Q;
  logic Q_n;
`ifdef SR_TO_T_DEBUG_EN
  logic sr_s;
  logic sr_r;
  logic sr_illegal;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  sr_to_t_ff dut (
    .clk        (clk),
    .reset      (reset),
    .T          (T),
    .Q          (Q),
    .Q_n        (Q_n)
`ifdef SR_TO_T_DEBUG_EN
    ,
    .sr_s       (sr_s),
    .sr_r       (sr_r),
    .sr_illegal (sr_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Check all outputs against the hand-computed expected Q with T applied
  task automatic check_outputs(input string tag, input logic t, input logic exp_q);
    check({tag, " Q"}, Q, exp_q);
    check({tag, " Q_n"}, Q_n, ~exp_q);
`ifdef SR_TO_T_DEBUG_EN
    check({tag, " sr_s"}, sr_s, t & ~exp_q);
    check({tag, " sr_r"}, sr_r, t & exp_q);
    check({tag, " sr_illegal"}, sr_illegal, 1'b0);
`endif
  endtask

  // Apply inputs for one edge, then check outputs after the edge
  task automatic step(input string tag, input logic rst, input logic t, input logic exp_q);
    @(negedge clk);
    reset = rst;
    T     = t;
    @(posedge clk);
    #1;
    check_outputs(tag, t, exp_q);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    T        = 1'b0;

    // Reset, then reset held with T=1
    step("rst0", 1'b1, 1'b0, 1'b0);
    step("rst_t1a", 1'b1, 1'b1, 1'b0);
    step("rst_t1b", 1'b1, 1'b1, 1'b0);

    // Hold
    step("hold0", 1'b0, 1'b0, 1'b0);
    step("hold1", 1'b0, 1'b0, 1'b0);

    // Toggle sequence
    step("tog1", 1'b0, 1'b1, 1'b1);
    step("tog2", 1'b0, 1'b1, 1'b0);
    step("tog_hold", 1'b0, 1'b0, 1'b0);
    step("tog3", 1'b0, 1'b1, 1'b1);
    step("tog4", 1'b0, 1'b1, 1'b0);

    // Reset priority: reach Q=1, hold it, then reset with T=1
    step("pri_set", 1'b0, 1'b1, 1'b1);
    step("pri_hold", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    T     = 1'b1;
    #2;
    check("mid_rst_no_effect Q", Q, 1'b1);
    check("mid_rst_no_effect Q_n", Q_n, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("pri_rst", 1'b1, 1'b0);
    step("pri_release", 1'b0, 1'b1, 1'b1);
    step("pri_back0", 1'b0, 1'b1, 1'b0);

    // Divide-by-two: T held high for 8 edges from Q=0
    for (int i = 0; i < 8; i++) begin
      step($sformatf("div%0d", i), 1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    step("div_stop", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_to_t_ff.md
# sr_to_t_ff

Single-bit toggle (T) flip-flop built from an internal SR flip-flop core plus T-to-SR excitation logic. It is a leaf cell in the sequential-elements library, used wherever a divide-by-two or a conditional toggle bit is needed. The SR core is kept explicit so its set/reset terms can be inspected and checked.

## Interface
- No parameters.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- T  input  1  toggle enable; 1 = invert Q at the next edge, 0 = hold.
- Q  output  1  registered flip-flop state.
- Q_n  output  1  always the complement of Q (combinational from the register).
- sr_s  output  1  internal set term; present only with SR_TO_T_DEBUG_EN.
- sr_r  output  1  internal reset term; present only with SR_TO_T_DEBUG_EN.
- sr_illegal  output  1  registered illegal-combination flag; present only with SR_TO_T_DEBUG_EN.

## Operation
- Excitation logic (combinational): S = T & ~Q; R = T & Q.
- SR core, evaluated at each rising clk edge:
  - S=0, R=0: hold.
  - S=1, R=0: Q <= 1.
  - S=0, R=1: Q <= 0.
  - S=1, R=1: illegal. Q holds its value. This combination cannot arise from the excitation logic; the core still defines it so it is never X-producing.
- Net behaviour: T=0 holds Q; T=1 gives Q <= ~Q.
- reset has priority over T. When reset=1 at an edge, Q <= 0 regardless of T.
- Q_n = ~Q at all times, including during and after reset.
- Q is undefined (X) from power-up until the first edge with reset=1. No implicit initial value.

## Timing
- Latency: one clock. T sampled at edge n determines Q after edge n.
- Reset is synchronous. Asserting reset between edges has no effect until the next rising edge. After the first edge with reset=1, Q=0 and Q_n=1.
- Deasserting reset: the first edge with reset=0 evaluates T normally.
- If reset is asserted mid-toggle sequence, the next edge forces Q=0 and discards T.
- T may change anywhere between edges. Only its value at the rising edge matters, subject to normal setup/hold.
- A continuously high T makes Q a clk/2 square wave.

## Configuration
- Macro: SR_TO_T_DEBUG_EN.
- When defined:
  - sr_s and sr_r ports exist and drive the combinational S and R terms.
  - sr_illegal is registered. It resets to 0 and is set to 1 at any edge where S=1 and R=1 with reset=0. It is sticky until reset.
  - A simulation-only check reports an error message at any such edge.
- When undefined: the three debug ports and the check are absent. Q and Q_n behaviour is identical in both builds.

## Test plan
- Power-up and reset: reset=1, T=0, one edge -> Q=0, Q_n=1. Holding reset=1 with T=1 for 2 edges -> Q stays 0.
- Hold: reset=0, T=0 for 2 edges -> Q stays 0.
- Toggle sequence: after reset, T=1 at two consecutive edges -> Q=1, then Q=0. T=0 at the next edge -> Q=0. T=1 at the next two edges -> Q=1, then 0.
- Reset priority: reach Q=1, then assert reset=1 with T=1 -> Q=0 after that edge. Deassert reset with T=1 -> Q=1 at the following edge.
- Divide-by-two: T=1 held for 8 edges from Q=0 -> Q toggles every edge (1,0,1,0,…), period = 2 clk cycles, Q_n always ~Q.
- Debug build (SR_TO_T_DEBUG_EN): over all of the above, sr_s = T & ~Q and sr_r = T & Q at every sample point. sr_illegal remains 0 throughout.
